// File: rtl/slot_pkg.sv
// Shared types and constants for the slot round controller and scorer.
package slot_pkg;

   typedef enum logic [1:0] {IDLE, SPIN, SETTLE, SCORE} judge_state_t;

   typedef logic [3:0] reel_t;

   localparam reel_t REEL_MAX = 4'd3;

endpackage

// File: rtl/slot_scorer.sv
// Combinational scoring of a frozen three-reel pattern into win flags and payout.
module slot_scorer
   import slot_pkg::*;
#(
   parameter int unsigned PAY3 = 5,
   parameter int unsigned PAY2 = 1
) (
   input  reel_t       h,
   input  reel_t       m,
   input  reel_t       l,
   output logic        win3,
   output logic        win2,
   output logic        bad,
   output logic [7:0]  payout
);

   always_comb begin
      win3   = 1'b0;
      win2   = 1'b0;
      payout = '0;
      bad    = (h > REEL_MAX) || (m > REEL_MAX) || (l > REEL_MAX);
      // An out-of-range reel voids the round even if the raw values match.
      if (!bad) begin
         if (h == m && m == l) begin
            win3   = 1'b1;
            payout = 8'(PAY3);
         end else if (h == m || m == l || h == l) begin
            win2   = 1'b1;
            payout = 8'(PAY2);
         end
      end
   end

endmodule

// File: rtl/slot_judge.sv
// Round controller: debits a credit per round, waits for stopped and stable reels,
// scores the frozen snapshot and pays out with saturation.
module slot_judge
   import slot_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned INIT_CREDIT   = 10,
   parameter int unsigned PAY3          = 5,
   parameter int unsigned PAY2          = 1,
   parameter int unsigned CREDIT_MAX    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  stop,
   input  reel_t       h,
   input  reel_t       m,
   input  reel_t       l,
   output logic [7:0]  credit,
   output logic        busy,
   output logic        result_valid,
   output logic        win3,
   output logic        win2,
   output logic        bad_reel
);

   localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

   judge_state_t  state, state_nxt;
   logic [CW-1:0] cnt;
   reel_t         snap_h, snap_m, snap_l;

   logic          debit, take_snap, cnt_inc, score;
   logic          s_win3, s_win2, s_bad;
   logic [7:0]    payout;
   logic [8:0]    sum;
   logic [7:0]    credit_paid;

   slot_scorer #(
      .PAY3 (PAY3),
      .PAY2 (PAY2)
   ) u_scorer (
      .h      (snap_h),
      .m      (snap_m),
      .l      (snap_l),
      .win3   (s_win3),
      .win2   (s_win2),
      .bad    (s_bad),
      .payout (payout)
   );

   assign sum         = {1'b0, credit} + {1'b0, payout};
   assign credit_paid = (sum > 9'(CREDIT_MAX)) ? 8'(CREDIT_MAX) : sum[7:0];

   assign busy         = (state != IDLE);
   assign result_valid = (state == SCORE);

   always_comb begin
      state_nxt = state;
      debit     = 1'b0;
      take_snap = 1'b0;
      cnt_inc   = 1'b0;
      score     = 1'b0;
      case (state)
         IDLE: begin
            if (start && credit != '0) begin
               debit     = 1'b1;
               state_nxt = SPIN;
            end
         end
         SPIN: begin
            if (stop == 3'b111) begin
               take_snap = 1'b1;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            // Payout and flags are committed on entry to SCORE so they
            // appear in the same cycle as result_valid.
            if (stop != 3'b111) begin
               state_nxt = SPIN;
            end else if ({h, m, l} != {snap_h, snap_m, snap_l}) begin
               take_snap = 1'b1;
            end else if (cnt == CNT_LAST) begin
               score     = 1'b1;
               state_nxt = SCORE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         SCORE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         credit   <= 8'(INIT_CREDIT);
         win3     <= 1'b0;
         win2     <= 1'b0;
         bad_reel <= 1'b0;
         cnt      <= '0;
         snap_h   <= '0;
         snap_m   <= '0;
         snap_l   <= '0;
      end else begin
         state <= state_nxt;
         if (debit) begin
            credit   <= credit - 8'd1;
            win3     <= 1'b0;
            win2     <= 1'b0;
            bad_reel <= 1'b0;
         end
         if (take_snap) begin
            snap_h <= h;
            snap_m <= m;
            snap_l <= l;
            cnt    <= '0;
         end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
         end
         if (score) begin
            credit   <= credit_paid;
            win3     <= s_win3;
            win2     <= s_win2;
            bad_reel <= s_bad;
         end
      end
   end

endmodule

// File: doc/slot_judge.md
# slot_judge

Round controller and scorer for the three-reel random display. It consumes the 4-bit reel values `h`, `m`, `l` and the per-reel stop controls that freeze them. It charges one credit per round, waits for all reels to be stopped and stable, then scores the frozen pattern and pays out. It sits beside the reel generator on the same fast clock and drives the credit and win indicators.

## Interface
Parameters:
- `SETTLE_CYCLES`, 16: consecutive cycles the stopped reels must hold unchanged before scoring (≥1).
- `INIT_CREDIT`, 10: credit value loaded at reset.
- `PAY3`, 5: payout when all three reels are equal.
- `PAY2`, 1: payout when exactly two reels are equal.
- `CREDIT_MAX`, 255: saturation ceiling of the credit register.

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a round.
- `stop`  in  3  reel freeze controls (bit2=h, bit1=m, bit0=l); 1 = reel held.
- `h`, `m`, `l`  in  4 each  reel values; legal range 0..3.
- `credit`  out  8  current credit.
- `busy`  out  1  high outside IDLE.
- `result_valid`  out  1  one-cycle pulse when a round is scored.
- `win3`  out  1  last round: three equal reels.
- `win2`  out  1  last round: exactly two equal reels.
- `bad_reel`  out  1  last round: at least one reel outside 0..3.

## Operation
- States: IDLE, SPIN, SETTLE, SCORE.
- IDLE:
  - `start`=1 and `credit`>0: credit is decremented by 1 and the state moves to SPIN.
  - `start`=1 and `credit`=0: the request is ignored and the state stays IDLE.
- SPIN: when `stop`==3'b111, the current {h,m,l} is captured into a snapshot, the settle counter is cleared, and the state moves to SETTLE.
- SETTLE:
  - Any `stop` bit at 0: return to SPIN.
  - {h,m,l} differs from the snapshot: take a new snapshot and clear the counter.
  - Otherwise the counter increments. When it reaches SETTLE_CYCLES−1, the state moves to SCORE.
- SCORE (exactly one cycle):
  - The snapshot is scored and `result_valid` pulses.
  - The flags are registered and the credit is updated.
  - The state moves to IDLE.
- Scoring rules:
  - If any reel has bit3 or bit2 set: `bad_reel`=1, payout is 0, and `win3`=`win2`=0.
  - Else if h==m==l: `win3`=1 and payout is PAY3.
  - Else if exactly one pair is equal: `win2`=1 and payout is PAY2.
  - Else payout is 0.
- Credit arithmetic: addition is 9-bit internally, and the result is clamped to CREDIT_MAX. Decrement happens only when credit>0, so there is no underflow.
- `win3`, `win2` and `bad_reel` hold until the next SCORE. They are cleared when a new round is accepted.
- `start` is ignored in SPIN, SETTLE and SCORE.
- `stop` may toggle freely in SPIN without effect.

## Timing
- Reset values: state=IDLE, `credit`=INIT_CREDIT, `busy`=0, `result_valid`=0, `win3`=`win2`=`bad_reel`=0, counter=0, snapshot=0.
- Asserting reset mid-round abandons the round. The debited credit is not refunded; credit reloads to INIT_CREDIT.
- `start` sampled high in IDLE: the decrement and `busy`=1 are visible on the next edge.
- Stop-to-score latency: from the first cycle `stop`==111 in SPIN with stable reels, `result_valid` asserts SETTLE_CYCLES+1 edges later. The credit payout is visible in the same cycle as `result_valid`.
- SCORE→IDLE takes one cycle. A `start` held high is honoured no earlier than the cycle after `result_valid`.
- Reels may change at any time relative to `clk`. Stability filtering relies only on the snapshot compare; no synchronizers are required because the inputs come from the same clock domain.

## Structure
- Shared package `slot_pkg` holds:
  - the state enum `judge_state_t` {IDLE, SPIN, SETTLE, SCORE};
  - the reel value type `reel_t` (logic [3:0]);
  - the `REEL_MAX`=3 constant.
- Sub-module `slot_scorer`: combinational. It takes the three `reel_t` values and outputs win3, win2, bad and payout. It is instantiated once by `slot_judge`.
- The settle counter width is $clog2(SETTLE_CYCLES+1).

## Test plan
- Reset with defaults → `credit`=10 and all flags 0. `start` with `stop` and reels at {2,2,2} held for 16 cycles → `credit`=9 after start, `result_valid` pulse, `win3`=1, `credit`=14.
- Reels {1,3,1} → `win2`=1 and `credit` changes 10→9→10. Reels {0,1,2} → no win and `credit` ends at 9.
- Reel h=4'b0110 while stopped → `bad_reel`=1, no payout, `credit` ends at 9.
- In SETTLE, change `m` at cycle 10 → counter restarts and `result_valid` arrives 16 cycles after the change. Drop `stop[0]` in SETTLE → back to SPIN and no result.
- Credit=0 with `start` pulses → stays IDLE and `busy`=0. Credit=253 with a PAY3 win → `credit`=255 (252+5 clamped).
- Assert `rst` low during SETTLE → asynchronous return to IDLE with `credit`=10. `start` pulses during SPIN are ignored, with no extra debit.
